// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: shared types and helpers for the gate-cell self-test sequencer.
//   state_e        - sequencer states (2-bit encoding, visible on dbg_state)
//   COMBO_LAST     - index of the last {a,b} combination in a sweep
//   gate_expect()  - truth table of the mux-built gate cell: {a&b, a|b, ~a}
package gate_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [1:0] COMBO_LAST = 2'd3;

  // combo[1] is a, combo[0] is b. Result is {and, or, not}.
  function automatic logic [2:0] gate_expect(input logic [1:0] combo);
    logic a;
    logic b;
    a = combo[1];
    b = combo[0];
    return {a & b, a | b, ~a};
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// gate_ref_model: combinational golden model of the gate cell.
// Ports:
//   a_i, b_i  - gate inputs
//   exp_o     - expected {and_out, or_out, not_out}
module gate_ref_model
  import gate_bist_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  output logic [2:0] exp_o
);

  assign exp_o = gate_expect({a_i, b_i});

endmodule

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: self-test sequencer for the mux-built gate cell.
// Sweeps {a,b} through 00,01,10,11 NUM_PASSES times, holds each combination
// SETTLE_CYCLES cycles, then samples and_in/or_in/not_in for one cycle and
// compares against the golden model.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start               - one-cycle test request
//   a_drv, b_drv        - registered drive to the gate cell inputs
//   and_in/or_in/not_in - gate cell outputs
//   busy, done          - activity flag, one-cycle completion pulse
//   result_valid, pass  - result qualifiers (held in IDLE)
//   err_count, fail_vec - saturating mismatch count, per-combination fail map
//   dbg_state           - current sequencer state (gate_bist_pkg::state_e)
//
// Handshake: start is a request qualified by !busy; it is taken only in IDLE
// and dropped otherwise. Completion is the done pulse; err_count, fail_vec,
// pass are qualified by result_valid, which stays high until the next
// accepted start or reset.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a_drv,
  output logic             b_drv,
  input  logic             and_in,
  input  logic             or_in,
  input  logic             not_in,
  output logic             busy,
  output logic             done,
  output logic             result_valid,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec,
  output logic [1:0]       dbg_state
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] PASS_LAST   = 8'(NUM_PASSES - 1);

  state_e           state_q, state_d;
  logic [1:0]       combo_q, combo_d;
  logic [3:0]       settle_q, settle_d;
  logic [7:0]       pass_cnt_q, pass_cnt_d;
  logic [1:0]       drv_q, drv_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       fv_q, fv_d;
  logic             rv_q, rv_d;

  logic [2:0] exp_bits;
  logic       mismatch;

  gate_ref_model u_ref (
    .a_i   (combo_q[1]),
    .b_i   (combo_q[0]),
    .exp_o (exp_bits)
  );

  // The cell is combinational, so the value seen during SAMPLE is compared directly.
  assign mismatch = ({and_in, or_in, not_in} != exp_bits);

  always_comb begin
    state_d    = state_q;
    combo_d    = combo_q;
    settle_d   = settle_q;
    pass_cnt_d = pass_cnt_q;
    err_d      = err_q;
    fv_d       = fv_q;
    rv_d       = rv_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_DRIVE;
          combo_d    = 2'd0;
          settle_d   = 4'd0;
          pass_cnt_d = 8'd0;
          err_d      = '0;
          fv_d       = 4'd0;
          rv_d       = 1'b0;
        end
      end
      ST_DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = ST_SAMPLE;
          settle_d = 4'd0;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          if (err_q != {ERR_W{1'b1}}) err_d = err_q + 1'b1;
          fv_d[combo_q] = 1'b1;
        end
        if (combo_q != COMBO_LAST) begin
          combo_d = combo_q + 2'd1;
          state_d = ST_DRIVE;
        end else if (pass_cnt_q != PASS_LAST) begin
          combo_d    = 2'd0;
          pass_cnt_d = pass_cnt_q + 8'd1;
          state_d    = ST_DRIVE;
        end else begin
          state_d = ST_DONE;
          rv_d    = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Drive lines follow the combination only while sweeping; zero otherwise.
    drv_d = (state_d == ST_DRIVE || state_d == ST_SAMPLE) ? combo_d : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      combo_q    <= 2'd0;
      settle_q   <= 4'd0;
      pass_cnt_q <= 8'd0;
      drv_q      <= 2'b00;
      err_q      <= '0;
      fv_q       <= 4'd0;
      rv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      combo_q    <= combo_d;
      settle_q   <= settle_d;
      pass_cnt_q <= pass_cnt_d;
      drv_q      <= drv_d;
      err_q      <= err_d;
      fv_q       <= fv_d;
      rv_q       <= rv_d;
    end
  end

  assign a_drv        = drv_q[1];
  assign b_drv        = drv_q[0];
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign result_valid = rv_q;
  assign pass         = rv_q && (err_q == '0);
  assign err_count    = err_q;
  assign fail_vec     = fv_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// tb_gate_bist_ctrl: four controller instances with different parameters,
// each wrapped around a behavioural gate cell with a selectable fault.
//   inst 0: defaults            inst 1: NUM_PASSES=2
//   inst 2: SETTLE_CYCLES=3     inst 3: ERR_W=2, NUM_PASSES=2
// fault: 0 = good cell, 1 = and_out stuck-at-0, 2 = not_out = a
module tb_gate_bist_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] start_v = 4'b0;
  logic [3:0] a_v, b_v, and_v, or_v, not_v;
  logic [3:0] busy_v, done_v, rv_v, pass_v;
  logic [1:0] fault_v [4];
  logic [7:0] e0, e1, e2;
  logic [1:0] e3;
  logic [3:0] f0, f1, f2, f3;
  logic [1:0] s0, s1, s2, s3;

  for (genvar g = 0; g < 4; g++) begin : g_cell
    assign and_v[g] = (fault_v[g] == 2'd1) ? 1'b0 : (a_v[g] & b_v[g]);
    assign or_v[g]  = a_v[g] | b_v[g];
    assign not_v[g] = (fault_v[g] == 2'd2) ? a_v[g] : ~a_v[g];
  end

  gate_bist_ctrl u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a_drv(a_v[0]), .b_drv(b_v[0]),
    .and_in(and_v[0]), .or_in(or_v[0]), .not_in(not_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .result_valid(rv_v[0]), .pass(pass_v[0]),
    .err_count(e0), .fail_vec(f0), .dbg_state(s0));

  gate_bist_ctrl #(.NUM_PASSES(2)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a_drv(a_v[1]), .b_drv(b_v[1]),
    .and_in(and_v[1]), .or_in(or_v[1]), .not_in(not_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .result_valid(rv_v[1]), .pass(pass_v[1]),
    .err_count(e1), .fail_vec(f1), .dbg_state(s1));

  gate_bist_ctrl #(.SETTLE_CYCLES(3)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a_drv(a_v[2]), .b_drv(b_v[2]),
    .and_in(and_v[2]), .or_in(or_v[2]), .not_in(not_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .result_valid(rv_v[2]), .pass(pass_v[2]),
    .err_count(e2), .fail_vec(f2), .dbg_state(s2));

  gate_bist_ctrl #(.ERR_W(2), .NUM_PASSES(2)) u3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .a_drv(a_v[3]), .b_drv(b_v[3]),
    .and_in(and_v[3]), .or_in(or_v[3]), .not_in(not_v[3]), .busy(busy_v[3]),
    .done(done_v[3]), .result_valid(rv_v[3]), .pass(pass_v[3]),
    .err_count(e3), .fail_vec(f3), .dbg_state(s3));

  // Selected-instance view
  int         sel = 0;
  logic [7:0] err_s;
  logic [3:0] fv_s;
  logic [1:0] st_s;
  always_comb begin
    err_s = e0;
    fv_s  = f0;
    st_s  = s0;
    case (sel)
      1: begin err_s = e1; fv_s = f1; st_s = s1; end
      2: begin err_s = e2; fv_s = f2; st_s = s2; end
      3: begin err_s = {6'b0, e3}; fv_s = f3; st_s = s3; end
      default: ;
    endcase
  end

  int n_cmp  = 0;
  int n_fail = 0;
  logic [1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         inst;
    logic [1:0] fault;
    int         passes;
    int         settle;
    int         repulse_at;
    logic [7:0] err;
    logic [3:0] fv;
    logic       pass;
  } vec_t;

  // Run one test on instance v.inst; start driven in cycle 0, accepted at edge 0.
  task automatic run(input vec_t v, input string tag);
    int c;
    int extra;
    logic [1:0] e;
    sel = v.inst;
    fault_v[v.inst] = v.fault;
    for (int p = 0; p < v.passes; p++)
      for (int k = 0; k < 4; k++)
        for (int s = 0; s <= v.settle; s++) exp_q.push_back(2'(k));
    start_v[v.inst] = 1'b1;
    tick();
    start_v[v.inst] = 1'b0;
    c = 1;
    while (!done_v[v.inst] && c < 300) begin
      if (c == v.repulse_at) start_v[v.inst] = 1'b1;
      else start_v[v.inst] = 1'b0;
      check({tag, " busy"}, 32'(busy_v[v.inst]), 32'd1);
      if (exp_q.size() == 0) begin
        check({tag, " drive overrun"}, 32'(c), 32'(4 * v.passes * (v.settle + 1) + 1));
        e = 2'b00;
      end else begin
        e = exp_q.pop_front();
      end
      check({tag, " ab"}, {30'b0, a_v[v.inst], b_v[v.inst]}, {30'b0, e});
      tick();
      c++;
    end
    start_v[v.inst] = 1'b0;
    check({tag, " done cycle"}, 32'(c), 32'(4 * v.passes * (v.settle + 1) + 1));
    check({tag, " queue empty"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check({tag, " err_count"}, 32'(err_s), 32'(v.err));
    check({tag, " fail_vec"}, 32'(fv_s), 32'(v.fv));
    check({tag, " pass"}, 32'(pass_v[v.inst]), 32'(v.pass));
    check({tag, " result_valid"}, 32'(rv_v[v.inst]), 32'd1);
    check({tag, " ab in done"}, {30'b0, a_v[v.inst], b_v[v.inst]}, 32'd0);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done_v[v.inst]) extra++;
    end
    check({tag, " extra done"}, 32'(extra), 32'd0);
    check({tag, " idle busy"}, 32'(busy_v[v.inst]), 32'd0);
    check({tag, " held pass"}, 32'(pass_v[v.inst]), 32'(v.pass));
    check({tag, " held err"}, 32'(err_s), 32'(v.err));
  endtask

  vec_t vecs [6];

  initial begin
    for (int i = 0; i < 4; i++) fault_v[i] = 2'd0;
    vecs[0] = '{inst: 0, fault: 2'd0, passes: 1, settle: 1, repulse_at: 0, err: 8'd0, fv: 4'b0000, pass: 1'b1};
    vecs[1] = '{inst: 1, fault: 2'd1, passes: 2, settle: 1, repulse_at: 0, err: 8'd2, fv: 4'b1000, pass: 1'b0};
    vecs[2] = '{inst: 2, fault: 2'd2, passes: 1, settle: 3, repulse_at: 0, err: 8'd4, fv: 4'b1111, pass: 1'b0};
    vecs[3] = '{inst: 3, fault: 2'd2, passes: 2, settle: 1, repulse_at: 0, err: 8'd3, fv: 4'b1111, pass: 1'b0};
    vecs[4] = '{inst: 0, fault: 2'd1, passes: 1, settle: 1, repulse_at: 0, err: 8'd1, fv: 4'b1000, pass: 1'b0};
    vecs[5] = '{inst: 0, fault: 2'd0, passes: 1, settle: 1, repulse_at: 3, err: 8'd0, fv: 4'b0000, pass: 1'b1};

    // Reset state
    rst = 1'b1;
    start_v = 4'b1111;  // start together with rst must lose
    tick();
    tick();
    start_v = 4'b0;
    rst = 1'b0;
    check("rst busy", 32'(busy_v), 32'd0);
    check("rst done", 32'(done_v), 32'd0);
    check("rst result_valid", 32'(rv_v), 32'd0);
    check("rst pass", 32'(pass_v), 32'd0);
    check("rst ab", {24'b0, a_v, b_v}, 32'd0);
    check("rst err", {e0, e1, e2, 6'b0, e3}, 32'd0);
    check("rst fail_vec", {16'b0, f0, f1, f2, f3}, 32'd0);
    tick();

    for (int i = 0; i < 6; i++) run(vecs[i], $sformatf("vec%0d", i));

    // Reset during SAMPLE of combo 10 on a failing run
    sel = 0;
    fault_v[0] = 2'd2;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("mid state sample", 32'(st_s), 32'd2);
    check("mid ab", {30'b0, a_v[0], b_v[0]}, 32'd2);
    check("mid err before rst", 32'(err_s), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid rst state", 32'(st_s), 32'd0);
    check("mid rst busy", 32'(busy_v[0]), 32'd0);
    check("mid rst ab", {30'b0, a_v[0], b_v[0]}, 32'd0);
    check("mid rst err", 32'(err_s), 32'd0);
    check("mid rst fail_vec", 32'(fv_s), 32'd0);
    check("mid rst rv", 32'(rv_v[0]), 32'd0);
    tick();
    run(vecs[0], "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_bist_ctrl.md
Name: gate_bist_ctrl

Overview:
- Self-test sequencer wrapped around gates_using_mux.
- Upstream role: drives the a/b inputs through every 2-bit combination.
- Downstream role: samples and_out/or_out/not_out, compares them against the truth table (a&b, a|b, ~a), and reports pass/fail, an error count and a per-combination fail map.
- Used in the gate-level bring-up bench and for on-chip sanity of the mux-built gate cell.

Parameters:
SETTLE_CYCLES, 1, cycles a/b are held before sampling DUT outputs (legal 1..15)
NUM_PASSES, 1, full 4-combination sweeps per start (legal 1..255)
ERR_W, 8, width of error counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request to begin a test; ignored while busy
a_drv  out  1  drives DUT input a
b_drv  out  1  drives DUT input b
and_in  in  1  DUT and_out
or_in  in  1  DUT or_out
not_in  in  1  DUT not_out
busy  out  1  high in every non-IDLE state
done  out  1  one-cycle pulse when a test completes
result_valid  out  1  results below are valid; held until next accepted start
pass  out  1  result_valid and err_count==0
err_count  out  ERR_W  number of mismatching samples, saturating
fail_vec  out  4  bit[i] set if combination i ({a,b}=i) mismatched in any pass

Behaviour:
- Reset (synchronous, any state, including mid-test):
  - State IDLE.
  - a_drv=0, b_drv=0, busy=0, done=0, result_valid=0, pass=0, err_count=0, fail_vec=0.
  - Settle counter, combination counter and pass counter all 0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start=1 -> DRIVE next cycle.
  - On the accepting edge: clear err_count, fail_vec, result_valid; combo=0; pass_cnt=0; settle_cnt=0.
- DRIVE:
  - a_drv=combo[1], b_drv=combo[0], registered outputs.
  - Stays SETTLE_CYCLES cycles (settle_cnt counts 0..SETTLE_CYCLES-1), then -> SAMPLE.
- SAMPLE (one cycle):
  - a_drv/b_drv unchanged.
  - Compare {and_in,or_in,not_in} with expected {a&b, a|b, ~a} for the current combo.
  - Any of the three bits differing counts as one mismatch: err_count+1 (saturate at 2^ERR_W-1, no wrap) and fail_vec[combo] set.
  - combo<3: combo+1 -> DRIVE.
  - combo==3 and pass_cnt<NUM_PASSES-1: combo wraps to 0, pass_cnt+1 -> DRIVE.
  - Otherwise -> DONE.
- DONE (one cycle):
  - done=1, result_valid set, pass=(err_count==0) including the final sample's update.
  - a_drv/b_drv return to 0.
  - -> IDLE.
- Timing:
  - Combo order is 00,01,10,11 each pass.
  - Start accepted at edge k: done is high in cycle k + 4*NUM_PASSES*(SETTLE_CYCLES+1) + 1.
  - Defaults: start sampled at edge 0 -> done high in cycle 9; busy high cycles 1..9.
- start while busy (DRIVE/SAMPLE/DONE) is ignored, with no effect on counters.
- start in the same cycle as rst: rst wins.
- Results persist in IDLE until the next accepted start or reset.
- DUT is purely combinational; comparison uses the outputs present during SAMPLE, no extra pipeline.

Decomposition:
- Package gate_bist_pkg holds:
  - the state enum (IDLE/DRIVE/SAMPLE/DONE, 2-bit);
  - COMBO_LAST = 2'd3;
  - a function returning expected {and,or,not} for a 2-bit combo.
- Sub-module gate_ref_model: combinational golden model, {a,b} -> {and,or,not}. Instantiated by the controller and reusable by benches.

Test Plan:
- Defaults, correct gates_using_mux connected, start pulse at cycle 0:
  - a_drv/b_drv sequence 00,01,10,11 with 2 cycles each;
  - done at cycle 9; pass=1, err_count=0, fail_vec=0000.
- Faulty DUT model with and_out stuck-at-0, NUM_PASSES=2:
  - mismatch only on combo 11 -> err_count=2, fail_vec=1000, pass=0.
- Faulty not_out inverted (not_out=a), SETTLE_CYCLES=3:
  - every combo fails -> err_count=4, fail_vec=1111;
  - done 16 cycles after start accept + 1.
- ERR_W=2, NUM_PASSES=2, not_out inverted:
  - 8 mismatches -> err_count saturates at 3, fail_vec=1111.
- start re-pulsed during DRIVE:
  - ignored; single done pulse at expected cycle; results identical to the single-start run.
- rst asserted during the SAMPLE of combo 10 of a failing run:
  - next cycle IDLE with all outputs zero;
  - subsequent start on a good DUT yields pass=1.
